// File: rtl/output_display.sv
// output_display
// Scans the 16-bit memory-mapped output word onto a 4-digit, active-low,
// multiplexed seven-segment display. A new word is captured only at a frame
// boundary (end of digit 3), so a frame always shows one consistent value.
// Each captured change lights a "new data" flag, and the digit-0 decimal
// point, for FLASH_FRAMES frames.
//
// Parameters:
//   REFRESH_DIV  - Clk cycles each digit is lit (>= 2)
//   FLASH_FRAMES - frames NewData stays high after a change (1..255)
//   LZB          - 1 = blank leading-zero digits (digit 0 never blanked)
//
// Ports:
//   Clk     in   system clock, rising edge
//   Rst     in   asynchronous active-high reset
//   OutData in   [15:0] word from Memory Output
//   Blank   in   1 = all digits dark, scanning continues
//   Anode   out  [3:0] digit enables, active-low, bit i = digit i
//   Seg     out  [6:0] segments, active-low, {g,f,e,d,c,b,a}
//   Dp      out  decimal point, active-low
//   NewData out  high while the flash counter is nonzero
module output_display #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned FLASH_FRAMES = 64,
  parameter int unsigned LZB          = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [15:0] OutData,
  input  logic        Blank,
  output logic [3:0]  Anode,
  output logic [6:0]  Seg,
  output logic        Dp,
  output logic        NewData
);

  localparam int unsigned PcW = $clog2(REFRESH_DIV);
  localparam logic [PcW-1:0] PcLast = PcW'(REFRESH_DIV - 1);
  localparam logic [7:0] FlashInit = 8'(FLASH_FRAMES);

  logic [PcW-1:0] pc;
  logic [1:0]     idx;
  logic [15:0]    disp;
  logic [7:0]     flash;

  logic           tick;
  logic           frameEnd;
  logic [3:0]     nib;
  logic           digitBlank;
  logic           flashOn;
  logic [3:0]     anodeNext;
  logic [6:0]     segNext;
  logic           dpNext;

  function automatic logic [6:0] hexToSeg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign tick     = (pc == PcLast);
  assign frameEnd = tick && (idx == 2'd3);
  assign flashOn  = (flash != '0);
  assign nib      = disp[{idx, 2'b00} +: 4];

  // A digit is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    digitBlank = 1'b0;
    if (LZB != 0) begin
      case (idx)
        2'd1:    digitBlank = (disp[15:4] == '0);
        2'd2:    digitBlank = (disp[15:8] == '0);
        2'd3:    digitBlank = (disp[15:12] == '0);
        default: digitBlank = 1'b0;
      endcase
    end
  end

  always_comb begin
    anodeNext = (Blank || digitBlank) ? 4'hF : ~(4'b0001 << idx);
    segNext   = hexToSeg(nib);
    dpNext    = ~(flashOn && (idx == 2'd0) && !Blank);
  end

  // Scan counters and display capture.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pc    <= '0;
      idx   <= '0;
      disp  <= '0;
      flash <= '0;
    end else begin
      pc <= tick ? '0 : pc + 1'b1;
      if (tick) begin
        idx <= idx + 1'b1;
      end
      // Reload has priority over decay so a change always restarts the flash.
      if (frameEnd) begin
        if (OutData != disp) begin
          disp  <= OutData;
          flash <= FlashInit;
        end else if (flashOn) begin
          flash <= flash - 1'b1;
        end
      end
    end
  end

  // Registered outputs: one cycle behind the scan state they describe.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Anode   <= '1;
      Seg     <= '1;
      Dp      <= 1'b1;
      NewData <= 1'b0;
    end else begin
      Anode   <= anodeNext;
      Seg     <= segNext;
      Dp      <= dpNext;
      NewData <= flashOn;
    end
  end

endmodule

// File: tb/tb_output_display.sv
module tb_output_display;

  logic        Clk;
  logic        Rst;
  logic [15:0] OutData;
  logic        Blank;
  logic [3:0]  Anode;
  logic [6:0]  Seg;
  logic        Dp;
  logic        NewData;

  output_display #(
    .REFRESH_DIV (4),
    .FLASH_FRAMES(2),
    .LZB         (1)
  ) dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .OutData(OutData),
    .Blank  (Blank),
    .Anode  (Anode),
    .Seg    (Seg),
    .Dp     (Dp),
    .NewData(NewData)
  );

  typedef struct {
    int         at;
    int         scen;
    int         k;
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;
    logic       nd;
  } exp_t;

  exp_t sb[$];
  int   nsamp   = 0;
  int   ecnt    = 0;
  int   relBase = 0;
  int   tests   = 0;
  int   fails   = 0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Edges since the most recent reset release.
  always @(posedge Clk or posedge Rst) begin
    if (Rst) ecnt <= 0;
    else     ecnt <= ecnt + 1;
  end

  // Expected outputs as seen at the negedge following edge k after release.
  task automatic expAt(input int scen, input int k, input logic [3:0] a,
                       input logic [6:0] s, input logic dp, input logic nd);
    exp_t e;
    e.at = relBase + 1 + k;
    e.scen = scen;
    e.k = k;
    e.anode = a;
    e.seg = s;
    e.dp = dp;
    e.nd = nd;
    sb.push_back(e);
  endtask

  task automatic goEdge(input int k);
    while (ecnt < k) begin
      @(posedge Clk);
      #2;
    end
  endtask

  // Monitor: compares every negedge sample that has a pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      nsamp = nsamp + 1;
      while (sb.size() > 0 && sb[0].at <= nsamp) begin
        e = sb.pop_front();
        tests = tests + 1;
        if (e.at != nsamp || Anode !== e.anode || Seg !== e.seg ||
            Dp !== e.dp || NewData !== e.nd) begin
          fails = fails + 1;
          $display("FAIL s%0d_edge%0d: got Anode=%h Seg=%h Dp=%b NewData=%b, want Anode=%h Seg=%h Dp=%b NewData=%b",
                   e.scen, e.k, Anode, Seg, Dp, NewData, e.anode, e.seg, e.dp, e.nd);
        end
      end
    end
  end

  initial begin
    Rst = 1'b1;
    OutData = 16'h0000;
    Blank = 1'b0;
    repeat (3) @(posedge Clk);
    #2;
    Rst = 1'b0;
    relBase = nsamp;

    // Reset values, first digit, leading-zero blank of digit 1
    expAt(1, 0, 4'hF, 7'h7F, 1'b1, 1'b0);
    expAt(1, 1, 4'hE, 7'h40, 1'b1, 1'b0);
    expAt(1, 5, 4'hF, 7'h40, 1'b1, 1'b0);

    // Load and scan B00B, then flash decay
    OutData = 16'hB00B;
    expAt(2, 16, 4'hF, 7'h40, 1'b1, 1'b0);
    expAt(2, 17, 4'hE, 7'h03, 1'b0, 1'b1);
    expAt(2, 20, 4'hE, 7'h03, 1'b0, 1'b1);
    expAt(2, 21, 4'hD, 7'h40, 1'b1, 1'b1);
    expAt(2, 25, 4'hB, 7'h40, 1'b1, 1'b1);
    expAt(2, 29, 4'h7, 7'h03, 1'b1, 1'b1);
    expAt(4, 33, 4'hE, 7'h03, 1'b0, 1'b1);
    expAt(4, 48, 4'h7, 7'h03, 1'b1, 1'b1);
    expAt(4, 49, 4'hE, 7'h03, 1'b1, 1'b0);
    expAt(4, 65, 4'hE, 7'h03, 1'b1, 1'b0);

    // Leading-zero blanking with 0012
    goEdge(65);
    OutData = 16'h0012;
    expAt(3, 81, 4'hE, 7'h24, 1'b0, 1'b1);
    expAt(3, 85, 4'hD, 7'h79, 1'b1, 1'b1);
    expAt(3, 89, 4'hF, 7'h40, 1'b1, 1'b1);
    expAt(3, 93, 4'hF, 7'h40, 1'b1, 1'b1);

    // Tear-free update 1234 -> 4321 mid-frame, flash reload
    goEdge(93);
    OutData = 16'h1234;
    expAt(5, 97, 4'hE, 7'h19, 1'b0, 1'b1);
    expAt(5, 113, 4'hE, 7'h19, 1'b0, 1'b1);
    goEdge(117);
    OutData = 16'h4321;
    expAt(5, 118, 4'hD, 7'h30, 1'b1, 1'b1);
    expAt(5, 122, 4'hB, 7'h24, 1'b1, 1'b1);
    expAt(5, 126, 4'h7, 7'h79, 1'b1, 1'b1);
    expAt(5, 128, 4'h7, 7'h79, 1'b1, 1'b1);
    expAt(5, 129, 4'hE, 7'h79, 1'b0, 1'b1);
    expAt(5, 133, 4'hD, 7'h24, 1'b1, 1'b1);
    expAt(5, 137, 4'hB, 7'h30, 1'b1, 1'b1);
    expAt(5, 141, 4'h7, 7'h19, 1'b1, 1'b1);
    expAt(5, 145, 4'hE, 7'h79, 1'b0, 1'b1);
    expAt(5, 161, 4'hE, 7'h79, 1'b1, 1'b0);
    expAt(6, 170, 4'hB, 7'h30, 1'b1, 1'b0);

    // Blank for 10 cycles with a value change inside the window
    goEdge(170);
    Blank = 1'b1;
    OutData = 16'hABCD;
    expAt(6, 171, 4'hF, 7'h30, 1'b1, 1'b0);
    expAt(6, 175, 4'hF, 7'h19, 1'b1, 1'b0);
    expAt(6, 177, 4'hF, 7'h21, 1'b1, 1'b1);
    expAt(6, 180, 4'hF, 7'h21, 1'b1, 1'b1);
    expAt(6, 181, 4'hD, 7'h46, 1'b1, 1'b1);
    expAt(6, 185, 4'hB, 7'h03, 1'b1, 1'b1);
    expAt(6, 189, 4'h7, 7'h08, 1'b1, 1'b1);
    expAt(6, 193, 4'hE, 7'h21, 1'b0, 1'b1);
    goEdge(180);
    Blank = 1'b0;

    // Asynchronous reset mid-cycle, then restart from a clean state
    expAt(7, 200, 4'hF, 7'h7F, 1'b1, 1'b0);
    goEdge(200);
    Rst = 1'b1;
    repeat (3) @(posedge Clk);
    #2;
    Rst = 1'b0;
    relBase = nsamp;
    expAt(7, 0, 4'hF, 7'h7F, 1'b1, 1'b0);
    expAt(7, 1, 4'hE, 7'h40, 1'b1, 1'b0);
    expAt(7, 5, 4'hF, 7'h40, 1'b1, 1'b0);
    expAt(7, 16, 4'hF, 7'h40, 1'b1, 1'b0);
    expAt(7, 17, 4'hE, 7'h21, 1'b0, 1'b1);

    for (int i = 0; i < 60 && sb.size() > 0; i++) @(posedge Clk);
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expectations never sampled, want 0", sb.size());
      fails = fails + sb.size();
      tests = tests + sb.size();
    end
    @(negedge Clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
